prng_sample_arbiter: RTL and testbench

Round-robin arbiter that shares the single free-running 12-bit xorshift PRNG stream among several consumers, such as per-pixel jitter units and bounce-direction samplers. Each granted transaction captures two consecutive PRNG words as a (u, v) sample pair and returns it on a shared valid/ready response channel tagged with the requester index. It sits between the PRNG and the ray-generation/shading stages. It guarantees that no PRNG word is delivered to more than one consumer.

---
 rtl/prng_sample_arbiter.sv | 110 +++++++++++
 tb/tb_prng_sample_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_sample_arbiter.sv
// Round-robin arbiter that shares one PRNG stream among several consumers.
// Each grant captures two consecutive PRNG words and returns them as a (u, v) pair.
module prng_sample_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        rand_num,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic [11:0]        out_u,
    output logic [11:0]        out_v,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, CAP_U, CAP_V, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [11:0]       out_u_q, out_u_d;
    logic [11:0]       out_v_q, out_v_d;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic              found;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[ID_W-1:0];
    endfunction

    // Search from ptr upward with wrap; the first active request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = wrap_add(ptr_q, i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        out_id_d = out_id_q;
        out_u_d  = out_u_q;
        out_v_d  = out_v_q;
        ack      = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    out_id_d = winner;
                    state_d  = CAP_U;
                end
            end
            CAP_U: begin
                out_u_d = rand_num;
                state_d = CAP_V;
            end
            CAP_V: begin
                out_v_d = rand_num;
                state_d = RESP;
            end
            RESP: begin
                // The winner drops to lowest priority for the next arbitration.
                if (out_ready) begin
                    ack     = {{(NUM_REQ-1){1'b0}}, 1'b1} << out_id_q;
                    ptr_d   = wrap_add(out_id_q, 1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            out_id_q <= '0;
            out_u_q  <= '0;
            out_v_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            out_id_q <= out_id_d;
            out_u_q  <= out_u_d;
            out_v_q  <= out_v_d;
        end
    end

    assign out_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign out_id    = out_id_q;
    assign out_u     = out_u_q;
    assign out_v     = out_v_q;

endmodule

// File: tb/tb_prng_sample_arbiter.sv
// Self-checking bench for prng_sample_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_prng_sample_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [11:0]       rand_num = '0;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ-1:0] ack;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ID_W-1:0]   out_id;
    logic [11:0]       out_u;
    logic [11:0]       out_v;
    logic              busy;

    prng_sample_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .rand_num  (rand_num),
        .req       (req),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_u     (out_u),
        .out_v     (out_v),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit rand_data = 1'b0;

    // Reference model: a granted transaction is described by how many cycles
    // have elapsed since the grant, rather than by an FSM encoding.
    bit          m_active = 1'b0;
    int          m_age = 0;
    int          m_id = 0;
    int          m_ptr = 0;
    logic [11:0] m_u = '0;
    logic [11:0] m_v = '0;
    bit          m_after_reset = 1'b0;

    // Observed accepted responses, recorded from the DUT's ack pulses.
    int          dut_ids[$];
    int          dut_cyc[$];
    logic [11:0] dut_vals[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rrWinner(input logic [NUM_REQ-1:0] r, input int start);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Advance the model across one rising edge using the inputs of the ending cycle.
    task automatic modelStep();
        m_after_reset = 1'b0;
        if (rst) begin
            m_active      = 1'b0;
            m_age         = 0;
            m_id          = 0;
            m_ptr         = 0;
            m_u           = '0;
            m_v           = '0;
            m_after_reset = 1'b1;
        end else if (!m_active) begin
            if (req != '0) begin
                m_id     = rrWinner(req, m_ptr);
                m_active = 1'b1;
                m_age    = 1;
            end
        end else if (m_age == 1) begin
            m_u   = rand_num;
            m_age = 2;
        end else if (m_age == 2) begin
            m_v   = rand_num;
            m_age = 3;
        end else if (out_ready) begin
            m_ptr    = (m_id + 1) % NUM_REQ;
            m_active = 1'b0;
        end
    endtask

    task automatic checkCycle();
        logic               exp_valid;
        logic [NUM_REQ-1:0] exp_ack;
        exp_valid = m_active && (m_age >= 3);
        exp_ack   = (exp_valid && out_ready) ? NUM_REQ'(1 << m_id) : '0;
        checkOutput("busy", busy, m_active);
        checkOutput("out_valid", out_valid, exp_valid);
        checkOutput("ack", ack, exp_ack);
        if (exp_valid || m_after_reset) begin
            checkOutput("out_id", out_id, m_id);
            checkOutput("out_u", out_u, m_u);
            checkOutput("out_v", out_v, m_v);
        end
        if (ack != '0) begin
            dut_ids.push_back(int'(out_id));
            dut_cyc.push_back(cyc);
            dut_vals.push_back(out_u);
            dut_vals.push_back(out_v);
        end
    endtask

    // One clock cycle: model catches up, new inputs are driven, outputs are checked mid-cycle.
    task automatic applyStimulus(input bit r, input logic [NUM_REQ-1:0] rq, input bit rd);
        @(posedge clk);
        #1;
        modelStep();
        if (rst && !r) cyc = 0;
        else cyc++;
        rst       = r;
        req       = rq;
        out_ready = rd;
        rand_num  = rand_data ? 12'($urandom) : 12'(cyc);
        @(negedge clk);
        checkCycle();
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, '0, 1'b0);
        applyStimulus(1'b1, '0, 1'b0);
        dut_ids.delete();
        dut_cyc.delete();
        dut_vals.delete();
    endtask

    int exp_rr[5]  = '{0, 1, 2, 3, 0};
    int exp_rot[4] = '{0, 3, 0, 3};
    int dups;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] nxt;
    bit rr;
    bit rd;

    initial begin
        $display("[TB] starting prng_sample_arbiter bench");

        // Single request from requester 2.
        resetDut();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, (k >= 2 && k <= 5) ? 4'b0100 : 4'b0000, 1'b1);
            if (k == 3) checkOutput("single_busy_c3", busy, 1);
            if (k == 5) begin
                checkOutput("single_id", out_id, 2);
                checkOutput("single_u", out_u, 3);
                checkOutput("single_v", out_v, 4);
                checkOutput("single_ack", ack, 4'b0100);
            end
            if (k == 6) checkOutput("single_idle_c6", busy, 0);
        end
        checkOutput("single_ack_count", dut_ids.size(), 1);

        // All requesters held: strict rotation, one pair every 4 cycles.
        resetDut();
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_count", dut_ids.size(), 5);
        for (int i = 0; i < 5 && i < dut_ids.size(); i++) begin
            checkOutput($sformatf("rr_id%0d", i), dut_ids[i], exp_rr[i]);
            if (i > 0) checkOutput($sformatf("rr_gap%0d", i), dut_cyc[i] - dut_cyc[i-1], 4);
        end
        dups = 0;
        for (int i = 0; i < dut_vals.size(); i++) begin
            for (int j = i + 1; j < dut_vals.size(); j++) begin
                if (dut_vals[i] == dut_vals[j]) dups++;
            end
        end
        checkOutput("rr_unique_words", dups, 0);

        // Backpressure: out_ready low for 6 cycles after out_valid rises.
        resetDut();
        for (int k = 0; k < 13; k++) begin
            applyStimulus(1'b0, (k <= 9) ? 4'b0001 : 4'b0000, !(k >= 3 && k <= 8));
            if (k >= 3 && k <= 8) begin
                checkOutput("bp_hold_u", out_u, 1);
                checkOutput("bp_hold_v", out_v, 2);
                checkOutput("bp_hold_id", out_id, 0);
                checkOutput("bp_no_ack", ack, 0);
            end
        end
        checkOutput("bp_ack_count", dut_ids.size(), 1);
        if (dut_cyc.size() > 0) checkOutput("bp_ack_cycle", dut_cyc[0], 9);

        // Request 1 withdrawn while its transaction is in CAP_U.
        resetDut();
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, (k == 0) ? 4'b0010 : 4'b0000, 1'b1);
        checkOutput("withdraw_count", dut_ids.size(), 1);
        if (dut_ids.size() > 0) checkOutput("withdraw_id", dut_ids[0], 1);

        // Reset during CAP_V drops the pending transaction.
        resetDut();
        applyStimulus(1'b0, 4'b0100, 1'b1);
        applyStimulus(1'b0, 4'b0100, 1'b1);
        applyStimulus(1'b1, 4'b0100, 1'b1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 4'b1010, 1'b1);
            if (k == 0) begin
                checkOutput("rst_valid", out_valid, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_ack", ack, 0);
                checkOutput("rst_id", out_id, 0);
                checkOutput("rst_u", out_u, 0);
                checkOutput("rst_v", out_v, 0);
            end
        end
        checkOutput("rst_first_winner", (dut_ids.size() > 0) ? dut_ids[0] : -1, 1);

        // Two requesters alternate under round-robin.
        resetDut();
        for (int k = 0; k < 16; k++) applyStimulus(1'b0, 4'b1001, 1'b1);
        checkOutput("rot_count", dut_ids.size(), 4);
        for (int i = 0; i < 4 && i < dut_ids.size(); i++) begin
            checkOutput($sformatf("rot_id%0d", i), dut_ids[i], exp_rot[i]);
        end

        // Randomized traffic: requesters hold until acked, random backpressure and resets.
        resetDut();
        rand_data = 1'b1;
        pending   = '0;
        for (int k = 0; k < 400; k++) begin
            nxt = (pending & ~ack) | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 19) == 0) nxt = nxt & 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 149) == 0);
            rd = ($urandom_range(0, 9) < 7);
            applyStimulus(rr, nxt, rd);
            pending = nxt;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
